freq_meter: RTL and testbench

Gated frequency counter: counts rising edges of an external asynchronous signal over a fixed window of GATE_CYCLES+1 system clocks, then reports the count. It is the measuring end of the periodic-enable scheme: freq_divider generates ticks from clk, and freq_meter measures the tick rate of an incoming signal against clk. Results feed display/UART logic via a one-cycle valid pulse.

---
 rtl/freq_meter_pkg.sv | 16 +
 rtl/freq_meter_if.sv | 23 ++
 rtl/freq_meter_sync_edge_det.sv | 32 +++
 rtl/freq_meter.sv | 113 +++++++++++
 tb/tb_freq_meter.sv | 208 ++++++++++++++++++++
 5 files changed

// File: rtl/freq_meter_pkg.sv
// freq_meter_pkg: shared definitions for the gated frequency counter.
//   - FSM state encodings (IDLE, MEASURE, DONE) as legacy-compatible constants
//   - default gate length and counter width, shared with freq_divider users
package freq_meter_pkg;

  // 1 s window at 100 MHz, result directly in Hz
  localparam int unsigned DEF_GATE_CYCLES = 99_999_999;
  localparam int unsigned DEF_CNT_W       = 27;

  typedef logic [1:0] state_t;

  localparam state_t ST_IDLE    = 2'd0;
  localparam state_t ST_MEASURE = 2'd1;
  localparam state_t ST_DONE    = 2'd2;

endpackage

// File: rtl/freq_meter_if.sv
// freq_meter_if: request/result bundle between a frequency meter and its user.
//   start      : single-cycle measurement request (master -> slave)
//   busy       : measurement in progress or being reported (slave -> master)
//   freq_out   : edge count of the last completed window
//   freq_valid : one-cycle pulse when freq_out/overflow are updated
//   overflow   : last result saturated
// Modports: master = consumer (display/UART side), slave = the meter.
interface freq_meter_if
  import freq_meter_pkg::*;
#(
  parameter int unsigned CNT_W = DEF_CNT_W
) ();

  logic             start;
  logic             busy;
  logic [CNT_W-1:0] freq_out;
  logic             freq_valid;
  logic             overflow;

  modport master (output start, input busy, freq_out, freq_valid, overflow);
  modport slave  (input start, output busy, freq_out, freq_valid, overflow);

endinterface

// File: rtl/freq_meter_sync_edge_det.sv
// sync_edge_det: 2-FF synchronizer followed by a rising-edge detector.
// Reusable for any asynchronous level input (buttons, external clocks).
//   clk    : sampling clock
//   reset  : synchronous, active-high; clears all three flops
//   i_sig  : asynchronous input
//   o_edge : one-cycle pulse, 2-3 clk after a rising edge of i_sig
module sync_edge_det (
  input  logic clk,
  input  logic reset,
  input  logic i_sig,
  output logic o_edge
);

  logic r_s1;
  logic r_s2;
  logic r_s3;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_s1 <= 1'b0;
      r_s2 <= 1'b0;
      r_s3 <= 1'b0;
    end else begin
      r_s1 <= i_sig;
      r_s2 <= r_s1;
      r_s3 <= r_s2;
    end
  end

  assign o_edge = r_s2 & ~r_s3;

endmodule

// File: rtl/freq_meter.sv
// freq_meter: gated frequency counter. After a start request, counts rising
// edges of sig_in over GATE_CYCLES+1 clk cycles and reports the count with a
// one-cycle freq_valid pulse. The count saturates at 2^CNT_W-1 and overflow
// flags that an edge arrived while saturated.
//   clk    : system clock
//   reset  : synchronous, active-high; aborts any measurement, clears outputs
//   sig_in : asynchronous signal to measure
//   bus    : freq_meter_if.slave (start, busy, freq_out, freq_valid, overflow)
// Optional build macro FREQ_METER_CONT_EN: windows run back-to-back after the
// first start (one dead cycle per window while the result is reported).
module freq_meter
  import freq_meter_pkg::*;
#(
  parameter int unsigned GATE_CYCLES = DEF_GATE_CYCLES,
  parameter int unsigned CNT_W       = DEF_CNT_W
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         sig_in,
  freq_meter_if.slave  bus
);

  localparam int unsigned GATE_W = (GATE_CYCLES > 0) ? $clog2(GATE_CYCLES + 1) : 1;
  localparam logic [GATE_W-1:0] GATE_LAST = GATE_W'(GATE_CYCLES);

  state_t           r_state;
  logic [GATE_W-1:0] r_gate_cnt;
  logic [CNT_W-1:0] r_edge_cnt;
  logic             r_ovf;
  logic [CNT_W-1:0] r_freq_out;
  logic             r_freq_valid;
  logic             r_overflow;

  logic             w_edge;
  logic             w_gate_last;
  logic [CNT_W-1:0] w_cnt_nxt;
  logic             w_ovf_nxt;

  sync_edge_det u_sync (
    .clk    (clk),
    .reset  (reset),
    .i_sig  (sig_in),
    .o_edge (w_edge)
  );

  assign w_gate_last = (r_gate_cnt == GATE_LAST);

  // Counts including this cycle's edge, so the final gate cycle is counted
  // when the result is captured.
  always_comb begin
    w_cnt_nxt = r_edge_cnt;
    w_ovf_nxt = r_ovf;
    if (w_edge) begin
      if (&r_edge_cnt) w_ovf_nxt = 1'b1;
      else             w_cnt_nxt = r_edge_cnt + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state      <= ST_IDLE;
      r_gate_cnt   <= '0;
      r_edge_cnt   <= '0;
      r_ovf        <= 1'b0;
      r_freq_out   <= '0;
      r_freq_valid <= 1'b0;
      r_overflow   <= 1'b0;
    end else begin
      r_freq_valid <= 1'b0;

      case (r_state)
        ST_IDLE: begin
          if (bus.start) r_state <= ST_MEASURE;
        end
        ST_MEASURE: begin
          if (w_gate_last) begin
            r_state      <= ST_DONE;
            r_freq_out   <= w_cnt_nxt;
            r_overflow   <= w_ovf_nxt;
            r_freq_valid <= 1'b1;
          end
        end
        ST_DONE: begin
`ifdef FREQ_METER_CONT_EN
          r_state <= ST_MEASURE;
`else
          r_state <= ST_IDLE;
`endif
        end
        default: r_state <= ST_IDLE;
      endcase

      // Counters only run inside the window; holding them at zero elsewhere
      // means every entry into MEASURE starts clean, and the DONE cycle's
      // edge is discarded.
      if (r_state == ST_MEASURE && !w_gate_last) begin
        r_gate_cnt <= r_gate_cnt + 1'b1;
        r_edge_cnt <= w_cnt_nxt;
        r_ovf      <= w_ovf_nxt;
      end else begin
        r_gate_cnt <= '0;
        r_edge_cnt <= '0;
        r_ovf      <= 1'b0;
      end
    end
  end

  assign bus.busy       = (r_state != ST_IDLE);
  assign bus.freq_out   = r_freq_out;
  assign bus.freq_valid = r_freq_valid;
  assign bus.overflow   = r_overflow;

endmodule

// File: tb/tb_freq_meter.sv
// tb_freq_meter: self-checking bench for freq_meter. Two instances (CNT_W=8
// and CNT_W=5, GATE_CYCLES=99) share clk, reset, sig_in and start. A reference
// model counts rising transitions of the recorded sig_in samples over the
// gate window (shifted by the synchronizer latency) and saturates the result.
module tb_freq_meter;

  localparam int unsigned GC = 99;

  logic clk    = 1'b0;
  logic reset  = 1'b1;
  logic sig_in = 1'b0;
  logic start  = 1'b0;

  freq_meter_if #(.CNT_W(8)) bus8 ();
  freq_meter_if #(.CNT_W(5)) bus5 ();

  assign bus8.start = start;
  assign bus5.start = start;

  freq_meter #(.GATE_CYCLES(GC), .CNT_W(8)) dut8 (
    .clk(clk), .reset(reset), .sig_in(sig_in), .bus(bus8)
  );
  freq_meter #(.GATE_CYCLES(GC), .CNT_W(5)) dut5 (
    .clk(clk), .reset(reset), .sig_in(sig_in), .bus(bus5)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // sig_in as seen at each posedge; a reset edge clears the synchronizer,
  // which looks to everything downstream like a sampled 0.
  int   cyc = 0;
  logic hist [0:4095];

  always @(posedge clk) begin
    if (cyc < 4096) hist[cyc] = reset ? 1'b0 : sig_in;
    cyc++;
  end

  // Stimulus generator: 0 = hold gen_hi!=0, 1 = periodic, 2 = random bits.
  int gen_mode = 1;
  int gen_per  = 6;
  int gen_hi   = 3;

  initial begin
    int ph = 0;
    forever begin
      @(negedge clk);
      case (gen_mode)
        0:       sig_in = (gen_hi != 0);
        1: begin
          sig_in = (ph < gen_hi);
          ph = (ph + 1) % gen_per;
        end
        default: sig_in = 1'($urandom_range(0, 1));
      endcase
    end
  end

  // Start sampled at posedge p0: the window covers edge strobes built from
  // samples p0-2 .. p0+GC-1 (two-flop synchronizer plus edge flop).
  function automatic int raw_edges(input int p0);
    int c = 0;
    for (int k = p0 - 1; k <= p0 - 1 + int'(GC); k++)
      if (hist[k] && !hist[k-1]) c++;
    return c;
  endfunction

  function automatic int sat(input int raw, input int w);
    int mx = (1 << w) - 1;
    return (raw > mx) ? mx : raw;
  endfunction

  task automatic check_all_zero(input string tag);
    check({tag, "_busy8"}, 32'(bus8.busy), 0);
    check({tag, "_val8"},  32'(bus8.freq_valid), 0);
    check({tag, "_out8"},  32'(bus8.freq_out), 0);
    check({tag, "_ovf8"},  32'(bus8.overflow), 0);
    check({tag, "_busy5"}, 32'(bus5.busy), 0);
    check({tag, "_val5"},  32'(bus5.freq_valid), 0);
    check({tag, "_out5"},  32'(bus5.freq_out), 0);
    check({tag, "_ovf5"},  32'(bus5.overflow), 0);
  endtask

  // One single-shot measurement. restart_at/reset_at: cycle offset (from the
  // start cycle) at which to pulse start/reset, or -1. c8/c5: optional fixed
  // expected counts, or -1.
  task automatic run_measure(input int restart_at, input int reset_at,
                             input int c8, input int c5);
    int   p0;
    int   raw;
    logic aborted;
    aborted = 1'b0;
    @(negedge clk);
    start = 1'b1;
    p0 = cyc;
    for (int n = 1; n <= 102; n++) begin
      @(negedge clk);
      check("busy8", 32'(bus8.busy), 32'(!aborted && n <= 101));
      check("busy5", 32'(bus5.busy), 32'(!aborted && n <= 101));
      check("valid8", 32'(bus8.freq_valid), 32'(!aborted && n == 101));
      check("valid5", 32'(bus5.freq_valid), 32'(!aborted && n == 101));
      if (aborted && n == reset_at + 1) check_all_zero("abort");
      if (!aborted && n == 101) begin
        raw = raw_edges(p0);
        check("out8", 32'(bus8.freq_out), 32'(sat(raw, 8)));
        check("ovf8", 32'(bus8.overflow), 32'(raw > 255));
        check("out5", 32'(bus5.freq_out), 32'(sat(raw, 5)));
        check("ovf5", 32'(bus5.overflow), 32'(raw > 31));
        if (c8 >= 0) check("dir_out8", 32'(bus8.freq_out), 32'(c8));
        if (c5 >= 0) check("dir_out5", 32'(bus5.freq_out), 32'(c5));
      end
      start = (n == restart_at);
      reset = (n == reset_at);
      if (n == reset_at) aborted = 1'b1;
    end
    start = 1'b0;
    reset = 1'b0;
  endtask

  initial begin
    // Reset held with sig_in toggling every 3 cycles and start pulsed.
    gen_mode = 1; gen_per = 6; gen_hi = 3;
    for (int i = 0; i < 24; i++) begin
      @(negedge clk);
      start = ((i % 5) == 2);
      if (i >= 2) check_all_zero("rst");
    end
    start = 1'b0;
    reset = 1'b0;
    repeat (3) @(negedge clk);
    check_all_zero("post_rst");

`ifdef FREQ_METER_CONT_EN
    begin
      int p0;
      int raw;
      gen_mode = 1; gen_per = 4; gen_hi = 2;
      repeat (20) @(negedge clk);
      start = 1'b1;
      p0 = cyc;
      for (int n = 1; n <= 303; n++) begin
        @(negedge clk);
        start = 1'b0;
        check("c_busy8", 32'(bus8.busy), 1);
        check("c_valid8", 32'(bus8.freq_valid), 32'((n % 101) == 0));
        check("c_valid5", 32'(bus5.freq_valid), 32'((n % 101) == 0));
        if ((n % 101) == 0) begin
          raw = raw_edges(p0 + 101 * (n / 101 - 1));
          check("c_out8", 32'(bus8.freq_out), 32'(sat(raw, 8)));
          check("c_out5", 32'(bus5.freq_out), 32'(sat(raw, 5)));
          check("c_dir8", 32'(bus8.freq_out), 25);
          check("c_ovf8", 32'(bus8.overflow), 0);
        end
      end
    end
`else
    // Period 10, started well before start.
    gen_mode = 1; gen_per = 10; gen_hi = 5;
    repeat (20) @(negedge clk);
    run_measure(-1, -1, 10, 10);

    // Toggling every clk: 50 edges, saturates the 5-bit instance.
    gen_mode = 1; gen_per = 2; gen_hi = 1;
    repeat (10) @(negedge clk);
    run_measure(-1, -1, 50, 31);

    // start re-pulsed mid-window, then in the DONE cycle; both ignored.
    gen_mode = 1; gen_per = 7; gen_hi = 3;
    repeat (5) @(negedge clk);
    run_measure(40, -1, -1, -1);
    repeat (5) @(negedge clk);
    run_measure(101, -1, -1, -1);
    repeat (5) @(negedge clk);
    run_measure(-1, -1, -1, -1);

    // Reset mid-window aborts, then a fresh measurement.
    gen_mode = 1; gen_per = 4; gen_hi = 2;
    repeat (5) @(negedge clk);
    run_measure(-1, 50, -1, -1);
    repeat (5) @(negedge clk);
    run_measure(-1, -1, 25, 25);

    // Randomized signals.
    for (int r = 0; r < 8; r++) begin
      gen_mode = int'($urandom_range(1, 2));
      gen_per  = int'($urandom_range(2, 20));
      gen_hi   = int'($urandom_range(1, gen_per - 1));
      repeat ($urandom_range(3, 15)) @(negedge clk);
      run_measure(-1, -1, -1, -1);
    end
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
